// File: rtl/tcs34725_pkg.sv
// Shared constants and types for the TCS34725 I2C target emulation.
package tcs34725_pkg;

  localparam logic [6:0] DEF_ADDR   = 7'h29;
  localparam logic [7:0] DEF_DEV_ID = 8'h44;

  localparam logic [4:0] REG_ENABLE  = 5'h00;
  localparam logic [4:0] REG_ATIME   = 5'h01;
  localparam logic [4:0] REG_CONTROL = 5'h0F;
  localparam logic [4:0] REG_ID      = 5'h12;
  localparam logic [4:0] REG_STATUS  = 5'h13;
  localparam logic [4:0] REG_CDATAL  = 5'h14;

  // Command byte fields: CMD flag, TYPE[6:5], ADDR[4:0]
  localparam int CMD_BIT     = 7;
  localparam int CMD_TYPE_HI = 6;
  localparam int CMD_TYPE_LO = 5;
  localparam int CMD_ADDR_HI = 4;

  typedef enum logic [1:0] {
    CT_REPEAT  = 2'b00,
    CT_AUTOINC = 2'b01,
    CT_RSVD    = 2'b10,
    CT_SPECIAL = 2'b11
  } cmd_type_e;

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_CMD, ST_CMD_ACK,
    ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RACK_WAIT
  } state_e;

  function automatic logic [4:0] next_ptr(input logic [4:0] p, input cmd_type_e t);
    return (t == CT_AUTOINC) ? p + 5'd1 : p;
  endfunction

endpackage

// File: rtl/tcs34725_if.sv
// Host-side view of the emulated sensor: channel data in, configuration out.
interface tcs34725_if;
  logic [15:0] clear_in, red_in, green_in, blue_in;
  logic        data_valid;
  logic [7:0]  enable_reg, atime_reg;
  logic [1:0]  gain;
  logic        busy;

  modport master (output clear_in, red_in, green_in, blue_in, data_valid,
                  input  enable_reg, atime_reg, gain, busy);
  modport slave  (input  clear_in, red_in, green_in, blue_in, data_valid,
                  output enable_reg, atime_reg, gain, busy);
endinterface

// File: rtl/i2c_line_sync.sv
// 2-FF synchronizers on SCL/SDA with registered edge and START/STOP detection.
module i2c_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic scl,
  input  logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);
  logic [1:0] scl_sync, sda_sync;
  logic       scl_d, sda_d;

  // Idle bus is high on both lines, so reset to 1 to avoid a spurious edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync  <= 2'b11;
      sda_sync  <= 2'b11;
      scl_d     <= 1'b1;
      sda_d     <= 1'b1;
      scl_rise  <= 1'b0;
      scl_fall  <= 1'b0;
      start_det <= 1'b0;
      stop_det  <= 1'b0;
    end else begin
      scl_sync  <= {scl_sync[0], scl};
      sda_sync  <= {sda_sync[0], sda};
      scl_d     <= scl_sync[1];
      sda_d     <= sda_sync[1];
      scl_rise  <= scl_sync[1] & ~scl_d;
      scl_fall  <= ~scl_sync[1] & scl_d;
      start_det <= scl_sync[1] & scl_d & sda_d & ~sda_sync[1];
      stop_det  <= scl_sync[1] & scl_d & ~sda_d & sda_sync[1];
    end
  end

  assign sda_s = sda_sync[1];

endmodule

// File: rtl/tcs34725_target.sv
// I2C target emulating the TCS34725: protocol FSM, pointer, register file, shadows.
module tcs34725_target
  import tcs34725_pkg::*;
#(
  parameter logic [6:0] ADDR   = DEF_ADDR,
  parameter logic [7:0] DEV_ID = DEF_DEV_ID
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SCL,
  inout  wire         SDA,
  tcs34725_if.slave   host
);
  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_line_sync u_sync (
    .clk(clk), .rst(rst), .scl(SCL), .sda(SDA),
    .scl_rise(scl_rise), .scl_fall(scl_fall),
    .start_det(start_det), .stop_det(stop_det), .sda_s(sda_s)
  );

  state_e     state, state_n;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic [4:0] ptr;
  cmd_type_e  cmd_type;
  logic       rw, sda_low, busy_q, avalid;
  logic [7:0] enable_q, atime_q;
  logic [1:0] gain_q;
  // CDATAL is served live at snapshot time, so only its high byte needs a shadow.
  logic [7:0]  sh_c_hi;
  logic [15:0] sh_r, sh_g, sh_b;

  logic       ev_ok, byte_end, wr_en, ld_tx, avalid_clr;
  logic [7:0] rx_byte, rd_data;
  cmd_type_e  cmd_t;

  assign ev_ok      = !start_det && !stop_det;
  assign byte_end   = scl_rise && (bit_cnt == 3'd7);
  assign rx_byte    = {shreg[6:0], sda_s};
  assign cmd_t      = cmd_type_e'(rx_byte[CMD_TYPE_HI:CMD_TYPE_LO]);
  assign wr_en      = ev_ok && (state == ST_WDATA) && byte_end;
  assign ld_tx      = ev_ok && scl_fall &&
                      (((state == ST_ADDR_ACK) && sda_low && rw) || (state == ST_RACK_WAIT));
  assign avalid_clr = wr_en && (ptr == REG_ENABLE) && !rx_byte[1];

  always_comb begin
    rd_data = 8'h00;
    case (ptr)
      REG_ENABLE:  rd_data = enable_q;
      REG_ATIME:   rd_data = atime_q;
      REG_CONTROL: rd_data = {6'b0, gain_q};
      REG_ID:      rd_data = DEV_ID;
      REG_STATUS:  rd_data = {7'b0, avalid};
      REG_CDATAL:  rd_data = host.clear_in[7:0];
      5'h15:       rd_data = sh_c_hi;
      5'h16:       rd_data = sh_r[7:0];
      5'h17:       rd_data = sh_r[15:8];
      5'h18:       rd_data = sh_g[7:0];
      5'h19:       rd_data = sh_g[15:8];
      5'h1A:       rd_data = sh_b[7:0];
      5'h1B:       rd_data = sh_b[15:8];
      default:     rd_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // ACK states leave on the second SCL fall: the first one starts driving the ACK.
  always_comb begin
    state_n = state;
    if (stop_det)       state_n = ST_IDLE;
    else if (start_det) state_n = ST_ADDR;
    else begin
      case (state)
        ST_IDLE:      state_n = ST_IDLE;
        ST_ADDR:      if (byte_end) state_n = (rx_byte[7:1] == ADDR) ? ST_ADDR_ACK : ST_IDLE;
        ST_ADDR_ACK:  if (scl_fall && sda_low) state_n = rw ? ST_RDATA : ST_CMD;
        ST_CMD:       if (byte_end) state_n = rx_byte[CMD_BIT] ? ST_CMD_ACK : ST_IDLE;
        ST_CMD_ACK,
        ST_WDATA_ACK: if (scl_fall && sda_low) state_n = ST_WDATA;
        ST_WDATA:     if (byte_end) state_n = ST_WDATA_ACK;
        ST_RDATA:     if (scl_fall && (bit_cnt == 3'd7)) state_n = ST_RACK_WAIT;
        ST_RACK_WAIT: begin
          if (scl_rise && sda_s) state_n = ST_IDLE;
          else if (scl_fall)     state_n = ST_RDATA;
        end
        default:      state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt  <= '0;
      shreg    <= '0;
      ptr      <= '0;
      cmd_type <= CT_REPEAT;
      rw       <= 1'b0;
      sda_low  <= 1'b0;
      busy_q   <= 1'b0;
      avalid   <= 1'b0;
      enable_q <= 8'h00;
      atime_q  <= 8'hFF;
      gain_q   <= 2'b00;
      sh_c_hi  <= '0;
      sh_r     <= '0;
      sh_g     <= '0;
      sh_b     <= '0;
    end else begin
      avalid <= host.data_valid | (avalid & ~avalid_clr);
      if (stop_det) begin
        sda_low <= 1'b0;
        busy_q  <= 1'b0;
      end else if (start_det) begin
        sda_low <= 1'b0;
        busy_q  <= 1'b1;
        bit_cnt <= '0;
      end else begin
        case (state)
          ST_ADDR, ST_CMD, ST_WDATA: if (scl_rise) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
          end
          ST_ADDR_ACK, ST_CMD_ACK, ST_WDATA_ACK: if (scl_fall) begin
            sda_low <= ~sda_low;
            bit_cnt <= '0;
          end
          ST_RDATA: if (scl_fall) begin
            if (bit_cnt == 3'd7) sda_low <= 1'b0;
            else begin
              sda_low <= ~shreg[6];
              shreg   <= {shreg[6:0], 1'b0};
            end
            bit_cnt <= bit_cnt + 3'd1;
          end
          default: ;
        endcase

        if ((state == ST_ADDR) && byte_end) rw <= sda_s;
        if ((state == ST_CMD) && byte_end && rx_byte[CMD_BIT] && (cmd_t != CT_SPECIAL)) begin
          ptr      <= rx_byte[CMD_ADDR_HI:0];
          cmd_type <= cmd_t;
        end

        if (wr_en) begin
          case (ptr)
            REG_ENABLE:  enable_q <= rx_byte;
            REG_ATIME:   atime_q  <= rx_byte;
            REG_CONTROL: gain_q   <= rx_byte[1:0];
            default: ;
          endcase
          ptr <= next_ptr(ptr, cmd_type);
        end

        // Load overrides the ACK toggle above so the first data bit goes out on this fall.
        if (ld_tx) begin
          shreg   <= rd_data;
          sda_low <= ~rd_data[7];
          bit_cnt <= '0;
          ptr     <= next_ptr(ptr, cmd_type);
          if (ptr == REG_CDATAL) begin
            sh_c_hi <= host.clear_in[15:8];
            sh_r    <= host.red_in;
            sh_g    <= host.green_in;
            sh_b    <= host.blue_in;
          end
        end
      end
    end
  end

  assign SDA             = sda_low ? 1'b0 : 1'bz;
  assign host.enable_reg = enable_q;
  assign host.atime_reg  = atime_q;
  assign host.gain       = gain_q;
  assign host.busy       = busy_q;

endmodule

// File: tb/tb_tcs34725_target.sv
// Bit-banged I2C master driving the TCS34725 target against a transaction-level register model.
module tb_tcs34725_target;
  localparam int Q = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic scl = 1'b1;
  logic m_low = 1'b0;
  wire  SDA;

  pullup (SDA);
  assign SDA = m_low ? 1'b0 : 1'bz;

  tcs34725_if hif();
  tcs34725_target dut (.clk(clk), .rst(rst), .SCL(scl), .SDA(SDA), .host(hif));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int drv_cnt = 0;
  always @(negedge clk) if (SDA == 1'b0 && !m_low) drv_cnt <= drv_cnt + 1;

  // Register model
  logic [7:0]  m_en, m_at;
  logic [1:0]  m_gain;
  logic        m_av, m_inc;
  logic [4:0]  m_ptr;
  logic [15:0] m_sh [4];
  logic [15:0] chan [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    m_en = 8'h00; m_at = 8'hFF; m_gain = 2'b00; m_av = 1'b0;
    m_ptr = 5'd0; m_inc = 1'b0;
    for (int i = 0; i < 4; i++) m_sh[i] = 16'h0;
  endtask

  function automatic logic [7:0] m_val(input logic [4:0] a);
    logic [1:0]  idx;
    logic [15:0] w;
    if (a inside {[5'h14:5'h1B]}) begin
      idx = 2'((a - 5'h14) >> 1);
      w = m_sh[idx];
      return a[0] ? w[15:8] : w[7:0];
    end
    case (a)
      5'h00:   return m_en;
      5'h01:   return m_at;
      5'h0F:   return {6'b0, m_gain};
      5'h12:   return 8'h44;
      5'h13:   return {7'b0, m_av};
      default: return 8'h00;
    endcase
  endfunction

  task automatic m_write(input logic [7:0] d);
    case (m_ptr)
      5'h00: begin m_en = d; if (!d[1]) m_av = 1'b0; end
      5'h01: m_at = d;
      5'h0F: m_gain = d[1:0];
      default: ;
    endcase
    if (m_inc) m_ptr = m_ptr + 5'd1;
  endtask

  task automatic set_chan(input logic [15:0] c, input logic [15:0] r,
                          input logic [15:0] g, input logic [15:0] b);
    chan[0] = c; chan[1] = r; chan[2] = g; chan[3] = b;
    hif.clear_in = c; hif.red_in = r; hif.green_in = g; hif.blue_in = b;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic pulse_dv();
    @(negedge clk); hif.data_valid = 1'b1;
    @(negedge clk); hif.data_valid = 1'b0;
    m_av = 1'b1;
  endtask

  // Bus primitives: SDA changes a quarter period after SCL falls
  task automatic bus_start();
    m_low = 1'b0; tick(Q); scl = 1'b1; tick(Q); m_low = 1'b1; tick(Q); scl = 1'b0; tick(Q);
  endtask
  task automatic bus_stop();
    m_low = 1'b1; tick(Q); scl = 1'b1; tick(Q); m_low = 1'b0; tick(2*Q);
  endtask
  task automatic put_bit(input logic b);
    m_low = ~b; tick(Q); scl = 1'b1; tick(2*Q); scl = 1'b0; tick(Q);
  endtask
  task automatic get_bit(output logic b);
    m_low = 1'b0; tick(Q); scl = 1'b1; tick(Q); @(negedge clk); b = SDA; tick(Q); scl = 1'b0; tick(Q);
  endtask
  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) put_bit(d[i]);
    get_bit(b);
    ack = ~b;
  endtask
  task automatic rd_byte(output logic [7:0] d, input logic mack);
    logic b;
    for (int i = 7; i >= 0; i--) begin get_bit(b); d[i] = b; end
    put_bit(~mack);
  endtask

  // Transactions, each keeping the model in step
  task automatic op_cmd(input logic [7:0] cmd);
    logic a;
    bus_start();
    wr_byte(8'h52, a); check("addr_w_ack", 32'(a), 32'd1);
    wr_byte(cmd, a);   check("cmd_ack", 32'(a), 32'd1);
    if (cmd[6:5] != 2'b11) begin m_ptr = cmd[4:0]; m_inc = (cmd[6:5] == 2'b01); end
  endtask
  task automatic op_wr(input logic [7:0] d);
    logic a;
    wr_byte(d, a); check("wr_ack", 32'(a), 32'd1);
    m_write(d);
  endtask
  task automatic op_rd(input int n, input logic scramble);
    logic a;
    logic [7:0] d, e;
    bus_start();
    wr_byte(8'h53, a); check("addr_r_ack", 32'(a), 32'd1);
    for (int i = 0; i < n; i++) begin
      if (m_ptr == 5'h14) for (int k = 0; k < 4; k++) m_sh[k] = chan[k];
      e = m_val(m_ptr);
      rd_byte(d, i != n - 1);
      check($sformatf("rd_data@%0d", i), 32'(d), 32'(e));
      if (m_inc) m_ptr = m_ptr + 5'd1;
      if (scramble && i == 0)
        set_chan(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
    end
    m_low = 1'b0; @(negedge clk);
    check("released_after_nack", 32'(SDA), 32'd1);
    bus_stop();
  endtask
  task automatic chk_regs(input string tag);
    check({tag, "_enable"}, 32'(hif.enable_reg), 32'(m_en));
    check({tag, "_atime"},  32'(hif.atime_reg),  32'(m_at));
    check({tag, "_gain"},   32'(hif.gain),       32'(m_gain));
    check({tag, "_busy"},   32'(hif.busy),       32'd0);
  endtask

  initial begin
    logic a;
    int d0, n;
    logic [4:0] p;
    hif.data_valid = 1'b0;
    set_chan(16'h0, 16'h0, 16'h0, 16'h0);
    m_reset();
    #2 rst = 1'b1;
    tick(4);
    @(negedge clk) rst = 1'b0;
    tick(4);
    @(negedge clk);
    chk_regs("reset");
    check("reset_sda", 32'(SDA), 32'd1);

    // ENABLE write
    op_cmd(8'h80); op_wr(8'h03);
    @(negedge clk); check("busy_in_xfer", 32'(hif.busy), 32'd1);
    bus_stop();
    check("enable_03", 32'(hif.enable_reg), 32'h03);
    chk_regs("wr_enable");

    // ID read with repeated START
    op_cmd(8'hB2); op_rd(1, 1'b0);

    // Coherent 8-byte channel burst
    set_chan(16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0);
    op_cmd(8'hB4); op_rd(8, 1'b1);

    // Wrong address: NACK and SDA never driven
    bus_start();
    d0 = drv_cnt;
    wr_byte(8'h54, a);
    check("wrong_addr_nack", 32'(a), 32'd0);
    check("wrong_addr_nodrive", 32'(drv_cnt - d0), 32'd0);
    bus_stop();

    // Command byte without CMD bit: NACK
    bus_start();
    wr_byte(8'h52, a); check("addr_ack_badcmd", 32'(a), 32'd1);
    wr_byte(8'h0F, a); check("badcmd_nack", 32'(a), 32'd0);
    bus_stop();

    // Pointer wraps 0x1F -> 0x00
    op_cmd(8'hBF); op_rd(2, 1'b0);

    // AVALID set and clear
    pulse_dv();
    op_cmd(8'hB3); op_rd(1, 1'b0);
    op_cmd(8'h80); op_wr(8'h01); bus_stop();
    op_cmd(8'hB3); op_rd(1, 1'b0);
    chk_regs("avalid_clr");

    // Randomized mixed traffic
    for (int it = 0; it < 16; it++) begin
      set_chan(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
      if ($urandom_range(0, 3) == 0) pulse_dv();
      if ($urandom_range(0, 1) == 0) begin
        case ($urandom_range(0, 3))
          0: p = 5'h00;
          1: p = 5'h01;
          2: p = 5'h0F;
          default: p = 5'($urandom);
        endcase
        op_cmd({1'b1, 1'b0, 1'($urandom), p});
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++) op_wr(8'($urandom));
        bus_stop();
        chk_regs("rand_wr");
      end else begin
        op_cmd({1'b1, 1'b0, 1'($urandom), 5'($urandom)});
        op_rd($urandom_range(1, 4), 1'($urandom));
      end
    end

    // Asynchronous reset while the target drives a 0 data bit
    op_cmd(8'hB2);
    bus_start();
    wr_byte(8'h53, a); check("addr_ack_prerst", 32'(a), 32'd1);
    @(negedge clk); check("target_drives_0", 32'(SDA), 32'd0);
    rst = 1'b1;
    #1 check("rst_releases_sda", 32'(SDA), 32'd1);
    m_reset();
    chk_regs("midrst");
    scl = 1'b1; tick(2*Q);
    @(negedge clk) rst = 1'b0;
    tick(4);
    op_cmd(8'hA1); op_wr(8'h5A); bus_stop();
    chk_regs("post_rst");
    op_cmd(8'hB2); op_rd(1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
